conv_col_maxpool: RTL and testbench
===================================

CONV_COL_MAXPOOL -- requirements
Module: conv_col_maxpool

Interface
REQ-001 Parameter DATA_WIDTH, default 16, FP16 element width.
REQ-002 Parameter IN_ROWS, default 24, conv output elements per column; must be even.
REQ-003 Parameter COL_W, default 6, column-index width.
REQ-004 Reset is rst, asynchronous, active-high; the clock is clk.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 col_valid  input  1  one-cycle pulse; a conv output column is present.
REQ-008 col_num  input  COL_W  index of the presented column (0-based).
REQ-009 col_data  input  IN_ROWS x DATA_WIDTH  unpacked array; FP16 conv results, row 0 first.
REQ-010 frame_done  input  1  pulse; the upstream convolution finished its frame.
REQ-011 pool_valid  output  1  one-cycle pulse; pooled column valid.
REQ-012 pool_col_num  output  COL_W  pooled column index (col_num of the odd column >> 1).
REQ-013 pool_data  output  IN_ROWS/2 x DATA_WIDTH  pooled FP16 column, registered.
REQ-014 pool_done  output  1  one-cycle pulse; frame flushed.
REQ-015 seq_err  output  1  sticky; column pairing violated since the last reset.

Function
REQ-016 The block shall perform 2x2 stride-2 max pooling over consecutive column pairs (2k, 2k+1), producing IN_ROWS/2 values per pair.
REQ-017 The FSM shall have states IDLE (no column held) and HOLD (even column buffered).
REQ-018 IDLE + col_valid with even col_num -> store the column, enter HOLD; odd col_num -> set seq_err, discard, stay in IDLE.
REQ-019 HOLD + col_valid with col_num == held+1 -> compute, pulse pool_valid on the next cycle, enter IDLE.
REQ-020 HOLD + col_valid with any other col_num -> set seq_err, drop the held column; an even col_num becomes the new held column (stay HOLD), an odd one -> IDLE.
REQ-021 pool_data[r] shall equal max(held[2r], held[2r+1], cur[2r], cur[2r+1]).
REQ-022 Latency: pool_valid, pool_col_num and pool_data shall update on the clock edge after the completing col_valid; pool_data holds until the next pool_valid.
REQ-023 The max comparison shall be an FP16 total order: sign-magnitude compare, with -0 equal to +0 (+0 returned), and NaN compared by bit pattern.
REQ-024 frame_done shall return the FSM to IDLE, discard any held column without flagging an error, and pulse pool_done on the next cycle.
REQ-025 If col_valid and frame_done occur in the same cycle, the column shall be processed first; a completed pair yields pool_valid and pool_done in the same cycle.
REQ-026 There is no backpressure; each col_valid pulse shall be consumed in the cycle it is presented.
REQ-027 A trailing unpaired column shall never produce output.

Reset
REQ-028 On rst, the state shall be IDLE and pool_valid, pool_col_num, pool_data, pool_done, seq_err and the held-column buffer shall all be 0, effective immediately.
REQ-029 Reset mid-pair shall discard the held column; the first post-reset column is treated from IDLE.

Configuration
REQ-030 Macro MAXPOOL_RELU_EN: when defined, every input element with its sign bit set shall be replaced by +0 before comparison, so pool_data is never negative.
REQ-031 Without MAXPOOL_RELU_EN, raw values shall be compared per REQ-023 and negative maxima shall pass through.

Structure
REQ-032 Package cnn_pkg shall hold the fp16_t typedef (logic [15:0]), FP16_POS_ZERO, and the pool FSM state enum.
REQ-033 Sub-module fp16_max2 shall be a combinational two-input FP16 max per REQ-023; a tree of three instances shall be used per output row.

Verification
REQ-034 Cols 0 and 1, rows 0..3 = 3C00, 4000, 3800, 4200 and 0000, 3E00, 4400, 3000 -> one cycle later pool_valid=1, pool_col_num=0, pool_data[0]=4000, pool_data[1]=4400.
REQ-035 RELU_EN, all inputs 0xBC00 (-1.0) -> pool_data all 0000; without RELU_EN -> all BC00.
REQ-036 Cols 0 then 2 -> seq_err=1, no pool_valid; a following col 3 -> pool_valid with pool_col_num=1.
REQ-037 Col 22 held, then col_valid(23) and frame_done in the same cycle -> pool_valid (pool_col_num=11) and pool_done in the same cycle.
REQ-038 rst asserted while col 4 is held, then col 5 -> seq_err=1 and no pool_valid; all outputs 0 during reset.
REQ-039 Inputs 8000 and 0000 in one window with the rest negative, no RELU_EN -> result 0000.

Source files
------------

// File: rtl/conv_col_maxpool_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types for the CNN column pipeline:
//   fp16_t          raw IEEE-754 half-precision bit pattern
//   FP16_POS_ZERO   canonical +0
//   pool_state_e    column-pairing FSM states (IDLE / HOLD)
//   fp16_relu       clamps any value with the sign bit set to +0
//   fp16_order_key  maps FP16 bits onto an unsigned key so that an unsigned
//                   compare yields the sign-magnitude total order
// Optional build macro used by importers: MAXPOOL_RELU_EN.
// -----------------------------------------------------------------------------
package cnn_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_POS_ZERO  = 16'h0000;
  localparam fp16_t FP16_SIGN_MASK = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,  // no column buffered
    HOLD = 1'b1   // even column buffered, waiting for its odd partner
  } pool_state_e;

  function automatic fp16_t fp16_relu(input fp16_t x);
    return x[15] ? FP16_POS_ZERO : x;
  endfunction

  // Positive values get the top bit set so they sort above all negatives;
  // negative values are inverted so a larger magnitude sorts lower.
  // NaN patterns fall out ordered by their bit pattern.
  function automatic fp16_t fp16_order_key(input fp16_t x);
    return x[15] ? ~x : (x | FP16_SIGN_MASK);
  endfunction

endpackage

// File: rtl/conv_col_maxpool_if.sv
// -----------------------------------------------------------------------------
// conv_col_maxpool_if
// Bundle between the convolution engine and the column max-pool stage.
//   col_valid/col_num/col_data/frame_done : upstream -> pool (one-cycle pulses)
//   pool_valid/pool_col_num/pool_data     : pooled column result
//   pool_done                             : frame flush acknowledge pulse
//   seq_err                               : sticky column-pairing error
// Modports: master = convolution side, slave = pooling block.
// -----------------------------------------------------------------------------
interface conv_col_maxpool_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_ROWS    = 24,
  parameter int COL_W      = 6
);

  logic                  col_valid;
  logic [COL_W-1:0]      col_num;
  logic [DATA_WIDTH-1:0] col_data [IN_ROWS];
  logic                  frame_done;

  logic                  pool_valid;
  logic [COL_W-1:0]      pool_col_num;
  logic [DATA_WIDTH-1:0] pool_data [IN_ROWS/2];
  logic                  pool_done;
  logic                  seq_err;

  modport master (
    output col_valid, col_num, col_data, frame_done,
    input  pool_valid, pool_col_num, pool_data, pool_done, seq_err
  );

  modport slave (
    input  col_valid, col_num, col_data, frame_done,
    output pool_valid, pool_col_num, pool_data, pool_done, seq_err
  );

endinterface

// File: rtl/conv_col_maxpool_fp16_max2.sv
// -----------------------------------------------------------------------------
// fp16_max2
// Combinational two-input FP16 maximum under a sign-magnitude total order.
//   a, b : FP16 operands
//   y    : the larger operand; when both are zeros of either sign the result
//          is +0. NaNs are ordered by their raw bit pattern.
// -----------------------------------------------------------------------------
module fp16_max2
  import cnn_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t y
);

  fp16_t key_a;
  fp16_t key_b;
  logic  both_zero;

  assign key_a     = fp16_order_key(a);
  assign key_b     = fp16_order_key(b);
  // -0 and +0 compare equal; resolve the tie to the canonical +0
  assign both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);

  assign y = both_zero       ? FP16_POS_ZERO :
             (key_a >= key_b) ? a : b;

endmodule

// File: rtl/conv_col_maxpool.sv
// -----------------------------------------------------------------------------
// conv_col_maxpool
// 2x2 stride-2 max pooling over consecutive conv output columns (2k, 2k+1).
// An even column is buffered; when its odd partner arrives the two are reduced
// row-pair-wise and the pooled column is registered one cycle later.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : conv_col_maxpool_if.slave (column input, pooled output, status)
// Parameters: DATA_WIDTH (16), IN_ROWS (24, even), COL_W (6).
// Build macro: MAXPOOL_RELU_EN -- when defined, negative inputs are clamped
// to +0 before comparison, so pooled values are never negative.
// -----------------------------------------------------------------------------
module conv_col_maxpool
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_ROWS    = 24,
  parameter int COL_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_col_maxpool_if.slave      bus
);

  localparam int OUT_ROWS = IN_ROWS / 2;

  pool_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] held_q [IN_ROWS];
  logic [DATA_WIDTH-1:0] held_d [IN_ROWS];
  logic [COL_W-1:0]      held_col_q, held_col_d;

  logic                  pool_valid_q, pool_valid_d;
  logic [COL_W-1:0]      pool_col_num_q, pool_col_num_d;
  logic [DATA_WIDTH-1:0] pool_data_q [OUT_ROWS];
  logic [DATA_WIDTH-1:0] pool_data_d [OUT_ROWS];
  logic                  pool_done_q, pool_done_d;
  logic                  seq_err_q, seq_err_d;

  // Comparison operands after the optional ReLU clamp
  logic [DATA_WIDTH-1:0] cur_in  [IN_ROWS];
  logic [DATA_WIDTH-1:0] held_in [IN_ROWS];
  logic [DATA_WIDTH-1:0] max_row [OUT_ROWS];
  logic                  pair_match;

  generate
    for (genvar gi = 0; gi < IN_ROWS; gi++) begin : g_in
`ifdef MAXPOOL_RELU_EN
      assign cur_in[gi]  = fp16_relu(bus.col_data[gi]);
      assign held_in[gi] = fp16_relu(held_q[gi]);
`else
      assign cur_in[gi]  = bus.col_data[gi];
      assign held_in[gi] = held_q[gi];
`endif
    end
  endgenerate

  // Per output row: reduce each column's row pair, then the two partial maxima.
  generate
    for (genvar gi = 0; gi < OUT_ROWS; gi++) begin : g_row
      fp16_t held_max;
      fp16_t cur_max;

      fp16_max2 u_held_max (
        .a (held_in[2*gi]),
        .b (held_in[2*gi+1]),
        .y (held_max)
      );

      fp16_max2 u_cur_max (
        .a (cur_in[2*gi]),
        .b (cur_in[2*gi+1]),
        .y (cur_max)
      );

      fp16_max2 u_win_max (
        .a (held_max),
        .b (cur_max),
        .y (max_row[gi])
      );
    end
  endgenerate

  // The held column is always even, so +1 cannot wrap and implies odd.
  assign pair_match = (bus.col_num == held_col_q + COL_W'(1));

  always_comb begin
    state_d        = state_q;
    held_d         = held_q;
    held_col_d     = held_col_q;
    pool_valid_d   = 1'b0;
    pool_col_num_d = pool_col_num_q;
    pool_data_d    = pool_data_q;
    pool_done_d    = 1'b0;
    seq_err_d      = seq_err_q;

    if (bus.col_valid) begin
      case (state_q)
        IDLE: begin
          if (!bus.col_num[0]) begin
            for (int r = 0; r < IN_ROWS; r++) held_d[r] = bus.col_data[r];
            held_col_d = bus.col_num;
            state_d    = HOLD;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        HOLD: begin
          if (pair_match) begin
            pool_valid_d   = 1'b1;
            pool_col_num_d = bus.col_num >> 1;
            pool_data_d    = max_row;
            state_d        = IDLE;
          end else begin
            // Out-of-order column: the held column is lost; an even newcomer
            // starts a fresh pair, an odd one leaves nothing to pair with.
            seq_err_d = 1'b1;
            if (!bus.col_num[0]) begin
              for (int r = 0; r < IN_ROWS; r++) held_d[r] = bus.col_data[r];
              held_col_d = bus.col_num;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Applied after the column so a same-cycle final pair still completes;
    // any half pair left behind is silently dropped.
    if (bus.frame_done) begin
      state_d     = IDLE;
      pool_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      held_col_q     <= '0;
      pool_valid_q   <= 1'b0;
      pool_col_num_q <= '0;
      pool_done_q    <= 1'b0;
      seq_err_q      <= 1'b0;
      for (int r = 0; r < IN_ROWS; r++)  held_q[r]      <= '0;
      for (int r = 0; r < OUT_ROWS; r++) pool_data_q[r] <= '0;
    end else begin
      state_q        <= state_d;
      held_q         <= held_d;
      held_col_q     <= held_col_d;
      pool_valid_q   <= pool_valid_d;
      pool_col_num_q <= pool_col_num_d;
      pool_data_q    <= pool_data_d;
      pool_done_q    <= pool_done_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign bus.pool_valid   = pool_valid_q;
  assign bus.pool_col_num = pool_col_num_q;
  assign bus.pool_done    = pool_done_q;
  assign bus.seq_err      = seq_err_q;

  generate
    for (genvar gi = 0; gi < OUT_ROWS; gi++) begin : g_out
      assign bus.pool_data[gi] = pool_data_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_conv_col_maxpool.sv
// -----------------------------------------------------------------------------
// tb_conv_col_maxpool
// Table of column pairs with expected pooled columns, applied in a loop, plus
// hand-written sequences for pairing errors, same-cycle flush, trailing
// column and mid-pair reset. Expected pooled columns go into a queue when the
// completing column is driven and are popped by a monitor on pool_valid.
// Honours MAXPOOL_RELU_EN in its reference model.
// -----------------------------------------------------------------------------
module tb_conv_col_maxpool;

  localparam int DW    = 16;
  localparam int ROWS  = 24;
  localparam int CW    = 6;
  localparam int OROWS = ROWS / 2;
  localparam int NVEC  = 11;

  typedef logic [ROWS-1:0][15:0]  col_t;
  typedef logic [OROWS-1:0][15:0] pool_t;
  typedef struct packed { col_t ev; col_t od; pool_t exp; } vec_t;
  typedef struct packed { logic [CW-1:0] col; pool_t d; } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_col_maxpool_if #(.DATA_WIDTH(DW), .IN_ROWS(ROWS), .COL_W(CW)) bus ();

  conv_col_maxpool #(.DATA_WIDTH(DW), .IN_ROWS(ROWS), .COL_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[NVEC];

`ifdef MAXPOOL_RELU_EN
  localparam logic [15:0] NEG_ONE_RES = 16'h0000;
`else
  localparam logic [15:0] NEG_ONE_RES = 16'hBC00;
`endif

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_in(input logic [15:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [15:0] ref_max(input logic [15:0] a, input logic [15:0] b);
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return 16'h0000;
    if (a[15] != b[15]) return a[15] ? b : a;
    if (!a[15]) return (a[14:0] >= b[14:0]) ? a : b;
    return (a[14:0] <= b[14:0]) ? a : b;
  endfunction

  function automatic pool_t ref_pool(input col_t ev, input col_t od);
    pool_t p;
    for (int r = 0; r < OROWS; r++)
      p[r] = ref_max(ref_max(ref_in(ev[2*r]), ref_in(ev[2*r+1])),
                     ref_max(ref_in(od[2*r]), ref_in(od[2*r+1])));
    return p;
  endfunction

  function automatic logic [15:0] rand_elem();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 16'($urandom_range(0, 65535));
      4:          return 16'h0000;
      5:          return 16'h8000;
      6:          return 16'h7E00;
      default:    return 16'hFC00;
    endcase
  endfunction

  function automatic col_t rand_col();
    col_t c;
    for (int r = 0; r < ROWS; r++) c[r] = rand_elem();
    return c;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int c, input pool_t d);
    exp_t e;
    e.col = CW'(c);
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic send_col(input int c, input col_t d, input logic fd);
    @(negedge clk);
    bus.col_valid  = 1'b1;
    bus.col_num    = CW'(c);
    for (int r = 0; r < ROWS; r++) bus.col_data[r] = d[r];
    bus.frame_done = fd;
    @(negedge clk);
    bus.col_valid  = 1'b0;
    bus.frame_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pool_valid"},   32'(bus.pool_valid),   32'd0);
    chk({tag, "_pool_col_num"}, 32'(bus.pool_col_num), 32'd0);
    chk({tag, "_pool_done"},    32'(bus.pool_done),    32'd0);
    chk({tag, "_seq_err"},      32'(bus.seq_err),      32'd0);
    for (int r = 0; r < OROWS; r++)
      chk($sformatf("%s_pool_data[%0d]", tag, r), 32'(bus.pool_data[r]), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.pool_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pool_valid: got pool_valid=1 col %0d, required no output",
                 bus.pool_col_num);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("pool out: col %0d row0 %h", bus.pool_col_num, bus.pool_data[0]);
        chk("pool_col_num", 32'(bus.pool_col_num), 32'(e.col));
        for (int r = 0; r < OROWS; r++)
          chk($sformatf("pool_data[%0d] col %0d", r, e.col), 32'(bus.pool_data[r]), 32'(e.d[r]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    col_t a, b, c;

    bus.col_valid  = 1'b0;
    bus.col_num    = '0;
    bus.frame_done = 1'b0;
    for (int r = 0; r < ROWS; r++) bus.col_data[r] = '0;

    rst = 1'b1;
    #2;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Table: directed entries first, random entries after
    tbl[0] = '0;
    tbl[0].ev[0] = 16'h3C00; tbl[0].ev[1] = 16'h4000;
    tbl[0].ev[2] = 16'h3800; tbl[0].ev[3] = 16'h4200;
    tbl[0].od[0] = 16'h0000; tbl[0].od[1] = 16'h3E00;
    tbl[0].od[2] = 16'h4400; tbl[0].od[3] = 16'h3000;
    tbl[0].exp[0] = 16'h4000;
    tbl[0].exp[1] = 16'h4400;

    for (int r = 0; r < ROWS; r++) begin
      tbl[1].ev[r] = 16'hBC00;
      tbl[1].od[r] = 16'hBC00;
      tbl[2].ev[r] = 16'hBC00;
      tbl[2].od[r] = 16'hBC00;
    end
    for (int r = 0; r < OROWS; r++) begin
      tbl[1].exp[r] = NEG_ONE_RES;
      tbl[2].exp[r] = NEG_ONE_RES;
    end
    tbl[2].ev[0]  = 16'h8000;
    tbl[2].od[0]  = 16'h0000;
    tbl[2].exp[0] = 16'h0000;

    for (int i = 3; i < NVEC; i++) begin
      tbl[i].ev  = rand_col();
      tbl[i].od  = rand_col();
      tbl[i].exp = ref_pool(tbl[i].ev, tbl[i].od);
    end

    for (int i = 0; i < NVEC; i++) begin
      send_col(2*i, tbl[i].ev, 1'b0);
      push_exp(i, tbl[i].exp);
      send_col(2*i+1, tbl[i].od, 1'b0);
      @(negedge clk);
      chk($sformatf("hold_valid_low vec %0d", i), 32'(bus.pool_valid), 32'd0);
      chk($sformatf("hold_data[0] vec %0d", i), 32'(bus.pool_data[0]), 32'(tbl[i].exp[0]));
      chk($sformatf("hold_data[%0d] vec %0d", OROWS-1, i),
          32'(bus.pool_data[OROWS-1]), 32'(tbl[i].exp[OROWS-1]));
    end
    chk("seq_err_clean_table", 32'(bus.seq_err), 32'd0);

    // Out-of-order: col 0 then col 2 -> error, col 2 becomes held, col 3 pairs
    a = rand_col(); b = rand_col(); c = rand_col();
    send_col(0, a, 1'b0);
    send_col(2, b, 1'b0);
    chk("seq_err_after_0_2", 32'(bus.seq_err), 32'd1);
    push_exp(1, ref_pool(b, c));
    send_col(3, c, 1'b0);

    // Final pair completed together with frame_done
    a = rand_col(); b = rand_col();
    send_col(22, a, 1'b0);
    push_exp(11, ref_pool(a, b));
    send_col(23, b, 1'b1);
    chk("same_cycle_pool_valid", 32'(bus.pool_valid), 32'd1);
    chk("same_cycle_pool_done",  32'(bus.pool_done),  32'd1);
    @(negedge clk);
    chk("pool_done_one_cycle", 32'(bus.pool_done), 32'd0);

    // Trailing unpaired column flushed by frame_done: no output
    a = rand_col();
    send_col(8, a, 1'b0);
    @(negedge clk);
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.frame_done = 1'b0;
    chk("flush_pool_done", 32'(bus.pool_done), 32'd1);
    a = rand_col(); b = rand_col();
    send_col(10, a, 1'b0);
    push_exp(5, ref_pool(a, b));
    send_col(11, b, 1'b0);

    // Reset while col 4 is held; col 5 afterwards must not pair
    a = rand_col();
    send_col(4, a, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    chk_all_zero("reset_held");
    rst = 1'b0;
    b = rand_col();
    send_col(5, b, 1'b0);
    chk("seq_err_after_reset_5", 32'(bus.seq_err), 32'd1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_pool_valid: got %0d outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
